token_frame_tx: RTL and testbench

Downstream framer for the tokenizer output. It captures a 64-bit token, its 16-bit tag and the validation/meta flags when the token becomes valid, then emits a fixed 13-byte frame over a byte-wide valid/ready interface. The frame layout is: sync, status, 8 token bytes, 2 tag bytes, checksum. It sits between the token encryptor and the chip output pins/host link, replacing raw 8-byte token streaming with a framed, checked transfer.

---
 rtl/cc_frame_pkg.sv | 14 +
 rtl/frame_chk_accum.sv | 23 ++
 rtl/token_frame_tx.sv | 100 ++++++++++
 tb/tb_token_frame_tx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cc_frame_pkg.sv
// cc_frame_pkg: state encoding, frame geometry and the CRC-8 byte step shared by the token framer
package cc_frame_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, STATUS, TOKEN, TAG, CHECK, GAP} frame_state_e;
  localparam int FRAME_LEN = 13;
  localparam int TOKEN_BEATS = 8;
  localparam int TAG_BEATS = 2;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/frame_chk_accum.sv
// frame_chk_accum: running frame check byte, XOR by default or CRC-8 when TOKEN_FRAME_CRC8_EN is defined
module frame_chk_accum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_data,
  output logic [7:0] o_chk
);
  logic [7:0] r_acc;
  logic [7:0] w_next;
`ifdef TOKEN_FRAME_CRC8_EN
  import cc_frame_pkg::*;
  assign w_next = crc8_byte(r_acc, i_data);
`else
  assign w_next = r_acc ^ i_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en) r_acc <= w_next;
  assign o_chk = r_acc;
endmodule

// File: rtl/token_frame_tx.sv
// token_frame_tx: frames a captured token as 13 bytes over valid/ready; TOKEN_FRAME_CRC8_EN selects a CRC-8 check byte
module token_frame_tx
  import cc_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        token_valid,
  input  logic [63:0] token64,
  input  logic [15:0] token_tag16,
  input  logic        luhn_valid,
  input  logic        meta_valid,
  input  logic        meta_hit,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        frame_busy,
  output logic        frame_done,
  output logic        overrun
);
  frame_state_e r_state, w_next;
  logic [63:0] r_token;
  logic [15:0] r_tag;
  logic        r_luhn, r_mv, r_mh, r_overrun;
  logic [4:0]  r_seq;
  logic [2:0]  r_beat;
  logic [7:0]  r_gap;
  logic        w_xfer, w_cap, w_last_gap, w_tag_end;
  logic [7:0]  w_chk;
  assign w_xfer     = byte_valid & byte_ready;
  assign w_cap      = (r_state == IDLE) & token_valid & !start;
  assign w_last_gap = r_gap == 8'(GAP_CYCLES - 1);
  assign w_tag_end  = (r_state == TAG) & (r_beat == 3'(TAG_BEATS - 1));
  assign byte_valid = (r_state != IDLE) & (r_state != GAP);
  assign frame_busy = r_state != IDLE;
  assign frame_done = w_xfer & (r_state == CHECK) & !start;
  assign overrun    = r_overrun;
  assign byte_out   = r_state == SYNC   ? SYNC_BYTE :
                      r_state == STATUS ? {r_luhn, r_mv, r_mh, r_seq} :
                      r_state == TOKEN  ? r_token[{r_beat, 3'b000} +: 8] :
                      r_state == TAG    ? (r_beat[0] ? r_tag[15:8] : r_tag[7:0]) :
                      r_state == CHECK  ? w_chk : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (start) w_next = IDLE;
    else
      case (r_state)
        IDLE:    if (token_valid) w_next = SYNC;
        SYNC:    if (w_xfer) w_next = STATUS;
        STATUS:  if (w_xfer) w_next = TOKEN;
        TOKEN:   if (w_xfer && r_beat == 3'(TOKEN_BEATS - 1)) w_next = TAG;
        TAG:     if (w_xfer && w_tag_end) w_next = CHECK;
        CHECK:   if (w_xfer) w_next = (GAP_CYCLES == 0) ? IDLE : GAP;
        GAP:     if (w_last_gap) w_next = IDLE;
        default: w_next = IDLE;
      endcase
  end
  // one beat counter serves both the token and tag phases, rolling 7->0 into TAG
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_token   <= '0;
      r_tag     <= '0;
      r_luhn    <= 1'b0;
      r_mv      <= 1'b0;
      r_mh      <= 1'b0;
      r_seq     <= '0;
      r_beat    <= '0;
      r_gap     <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_cap) begin
        r_token <= token64;
        r_tag   <= token_tag16;
        r_luhn  <= luhn_valid;
        r_mv    <= meta_valid;
        r_mh    <= meta_hit;
      end
      if (start || w_cap || (w_xfer && w_tag_end)) r_beat <= '0;
      else if (w_xfer && (r_state == TOKEN || r_state == TAG)) r_beat <= r_beat + 3'd1;
      r_gap <= (r_state == GAP && !start) ? r_gap + 8'd1 : '0;
      if (frame_done) r_seq <= r_seq + 5'd1;
      if (start) r_overrun <= 1'b0;
      else if (token_valid && r_state != IDLE) r_overrun <= 1'b1;
    end
  end
  frame_chk_accum u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (start | w_cap),
    .i_en   (w_xfer & (r_state == STATUS || r_state == TOKEN || r_state == TAG)),
    .i_data (byte_out),
    .o_chk  (w_chk)
  );
endmodule

// File: tb/tb_token_frame_tx.sv
// tb_token_frame_tx: scoreboard bench for token_frame_tx; expected bytes queued at issue, popped by a byte monitor
module tb_token_frame_tx;
  localparam int GAP = 2;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, token_valid = 1'b0;
  logic        luhn_valid = 1'b0, meta_valid = 1'b0, meta_hit = 1'b0, byte_ready = 1'b0;
  logic [63:0] token64 = '0;
  logic [15:0] token_tag16 = '0;
  logic [7:0]  byte_out;
  logic        byte_valid, frame_busy, frame_done, overrun;
  typedef struct {logic [7:0] b; logic done;} exp_t;
  exp_t q[$];
  int n_cmp = 0, n_err = 0, rdy_mode = 0;
  logic [4:0] exp_seq = '0;
  logic       hold = 1'b0;
  logic [7:0] held = '0;
  always #5 clk = ~clk;
  token_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .token_valid(token_valid),
    .token64(token64), .token_tag16(token_tag16), .luhn_valid(luhn_valid),
    .meta_valid(meta_valid), .meta_hit(meta_hit), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .frame_busy(frame_busy),
    .frame_done(frame_done), .overrun(overrun)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // consumer readiness: always ready, or the 1,0,0 repeating pattern
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #2;
      byte_ready = (rdy_mode == 0) ? 1'b1 : (k % 3 == 0);
      k++;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (hold) begin
        check("hold_valid", byte_valid, 1'b1);
        check("hold_byte", byte_out, held);
      end
      if (byte_valid && byte_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got %h expected no byte", byte_out);
        end else begin
          e = q.pop_front();
          check("byte", byte_out, e.b);
          check("frame_done", frame_done, e.done);
        end
      end
      hold = byte_valid & !byte_ready;
      held = byte_out;
    end else hold = 1'b0;
  end
  task automatic issue(input logic [63:0] tok, input logic [15:0] tag, input logic l, input logic mv,
                       input logic mh, input int n_push);
    logic [7:0] b[13];
    logic [7:0] c;
    b[0] = 8'hA5;
    b[1] = {l, mv, mh, exp_seq};
    for (int i = 0; i < 8; i++) b[2+i] = tok[8*i +: 8];
    b[10] = tag[7:0];
    b[11] = tag[15:8];
    c = 8'h00;
    for (int i = 1; i < 12; i++) begin
`ifdef TOKEN_FRAME_CRC8_EN
      for (int k = 7; k >= 0; k--) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i][k]) ? 8'h07 : 8'h00);
`else
      c = c ^ b[i];
`endif
    end
    b[12] = c;
    for (int i = 0; i < n_push; i++) q.push_back('{b[i], i == 12});
    token64 = tok;
    token_tag16 = tag;
    luhn_valid = l;
    meta_valid = mv;
    meta_hit = mh;
    token_valid = 1'b1;
    @(posedge clk);
    #1 token_valid = 1'b0;
    check("first_valid", byte_valid, 1'b1);
    check("first_byte", byte_out, 8'hA5);
  endtask
  task automatic finish_frame();
    int t, g;
    t = 0;
    g = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!frame_done && t < 400);
    check("frame_done_seen", frame_done, 1'b1);
    @(posedge clk);
    #1;
    while (frame_busy && g < 10) begin
      check("gap_valid", byte_valid, 1'b0);
      g++;
      @(posedge clk);
      #1;
    end
    check("gap_cycles", g, GAP);
    exp_seq = exp_seq + 5'd1;
  endtask
  initial begin
    #12;
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_valid", byte_valid, 1'b0);
    check("rst_busy", frame_busy, 1'b0);
    check("rst_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    issue(64'h0807060504030201, 16'hBBAA, 1'b1, 1'b1, 1'b0, 13);
    finish_frame();
    rdy_mode = 1;
    issue(64'h0807060504030201, 16'hBBAA, 1'b1, 1'b1, 1'b0, 13);
    finish_frame();
    rdy_mode = 0;
    issue(64'h1122334455667788, 16'h9911, 1'b0, 1'b1, 1'b1, 13);
    repeat (4) @(posedge clk);
    #1;
    token64 = 64'hDEADDEADDEADDEAD;
    token_valid = 1'b1;
    @(posedge clk);
    #1 token_valid = 1'b0;
    check("overrun_set", overrun, 1'b1);
    finish_frame();
    check("overrun_sticky", overrun, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("dropped_token_idle", frame_busy, 1'b0);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    issue(64'hCAFEF00DBAADBEEF, 16'h1234, 1'b1, 1'b0, 1'b1, 5);
    repeat (4) @(posedge clk);
    #1;
    check("abort_5th_byte", byte_out, 8'hAD);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("abort_valid", byte_valid, 1'b0);
    check("abort_busy", frame_busy, 1'b0);
    check("abort_queue", q.size(), 0);
    issue(64'h00FF00FF12345678, 16'h5A5A, 1'b0, 1'b0, 1'b0, 13);
    finish_frame();
    issue(64'h0102030405060708, 16'h0A0B, 1'b1, 1'b1, 1'b1, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", byte_valid, 1'b0);
    check("async_rst_busy", frame_busy, 1'b0);
    check("async_rst_byte", byte_out, 8'h00);
    exp_seq = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 33; i++) begin
      if (i == 0) issue(64'h0807060504030201, 16'hBBAA, 1'b1, 1'b1, 1'b0, 13);
      else issue({8{8'(i)}} ^ 64'h0123456789ABCDEF, 16'(i * 3), 1'(i), 1'(i >> 1), 1'(i >> 2), 13);
      finish_frame();
    end
    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
